// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control unit FSM
//
// Purpose: sequences FETCH, DECODE, EXEC, MEM and WB for each instruction
// and drives the per-cycle datapath strobes. Memory accesses wait on
// mem_ready with a MEM_TIMEOUT-cycle limit; stall freezes the FSM.
// Optional feature macro: MULTICYCLE_CONTROL_TRAP_EN (undefined encodings
// trap instead of executing as NOP).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   opcode, funct             IR[31:26] / IR[5:0], used from DECODE onward
//   mem_ready                 memory completes the current access
//   stall                     freeze state and wait counter, mask writes
//   pc_write, pc_write_cond   PC write / branch write gated by ALU zero
//   branch_ne                 invert the zero condition (BNE)
//   pc_source                 00 ALU, 01 ALUOut, 10 jump target, 11 rs
//   ir_write, i_or_d          IR load / memory address from ALUOut
//   mem_read, mem_write       memory strobes
//   reg_write, reg_dst        register write / dest 00 rt, 01 rd, 10 $31
//   mem_to_reg                00 ALUOut, 01 MDR, 10 PC, 11 imm<<16
//   alu_src_a, alu_src_b      A: 0 PC, 1 rs; B: rt, 4, sext imm, imm<<2
//   alu_op                    0 add, 1 sub, 2 funct, 3 immediate logic
//   shamt_sel                 ALU A takes shamt (SLL/SRL)
//   state                     FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 5
//   mem_fault, trap           timeout pulse / sticky trap flag

module multicycle_control #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int ALU_OP_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              opcode,
  input  logic [5:0]              funct,
  input  logic                    mem_ready,
  input  logic                    stall,
  output logic                    pc_write,
  output logic                    pc_write_cond,
  output logic                    branch_ne,
  output logic [1:0]              pc_source,
  output logic                    ir_write,
  output logic                    i_or_d,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    reg_write,
  output logic [1:0]              reg_dst,
  output logic [1:0]              mem_to_reg,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    shamt_sel,
  output logic [2:0]              state,
  output logic                    mem_fault,
  output logic                    trap
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  // Counter only needs to reach MEM_TIMEOUT-1: the cycle that would make it
  // MEM_TIMEOUT is the timeout cycle itself.
  localparam int            CW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          trap_q, trap_d;

  logic dec_rtype, dec_shift, dec_jr, dec_jalr, dec_j, dec_jal;
  logic dec_branch, dec_bne, dec_addi, dec_logi, dec_lui, dec_lw, dec_sw;
  logic dec_valid;
  logic mem_timeout;
  logic [1:0] alu_op_c;

  // Instruction class decode; opcode/funct come straight from the IR,
  // which is stable once ir_write has fired in FETCH.
  always_comb begin
    dec_rtype  = 1'b0;
    dec_shift  = 1'b0;
    dec_jr     = 1'b0;
    dec_jalr   = 1'b0;
    dec_j      = 1'b0;
    dec_jal    = 1'b0;
    dec_branch = 1'b0;
    dec_bne    = 1'b0;
    dec_addi   = 1'b0;
    dec_logi   = 1'b0;
    dec_lui    = 1'b0;
    dec_lw     = 1'b0;
    dec_sw     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL, FN_SRL: begin
            dec_rtype = 1'b1;
            dec_shift = 1'b1;
          end
          FN_JR:   dec_jr   = 1'b1;
          FN_JALR: dec_jalr = 1'b1;
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: dec_rtype = 1'b1;
          default: ;
        endcase
      end
      OP_J:    dec_j   = 1'b1;
      OP_JAL:  dec_jal = 1'b1;
      OP_BEQ:  dec_branch = 1'b1;
      OP_BNE: begin
        dec_branch = 1'b1;
        dec_bne    = 1'b1;
      end
      OP_ADDI: dec_addi = 1'b1;
      OP_ANDI, OP_ORI, OP_XORI: dec_logi = 1'b1;
      OP_LUI:  dec_lui = 1'b1;
      OP_LW:   dec_lw  = 1'b1;
      OP_SW:   dec_sw  = 1'b1;
      default: ;
    endcase
  end

  assign dec_valid = dec_rtype | dec_jr | dec_jalr | dec_j | dec_jal | dec_branch |
                     dec_addi | dec_logi | dec_lui | dec_lw | dec_sw;

  // Ready is checked first in the memory states, so a ready arriving on
  // the timeout cycle completes the access.
  assign mem_timeout = !mem_ready && (cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    trap_d        = trap_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = 2'b00;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op_c      = 2'd0;
    shamt_sel     = 1'b0;
    mem_fault     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (mem_timeout) begin
          mem_fault = 1'b1;
          state_d   = S_FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (dec_valid) begin
          state_d = S_EXEC;
        end else begin
`ifdef MULTICYCLE_CONTROL_TRAP_EN
          state_d = S_TRAP;
          trap_d  = 1'b1;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (dec_rtype) begin
          alu_src_a = 1'b1;
          alu_op_c  = 2'd2;
          shamt_sel = dec_shift;
          state_d   = S_WB;
        end else if (dec_jr || dec_jalr) begin
          pc_write  = 1'b1;
          pc_source = 2'b11;
          if (dec_jalr) begin
            reg_write  = 1'b1;
            reg_dst    = 2'b01;
            mem_to_reg = 2'b10;
          end
        end else if (dec_j || dec_jal) begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
          if (dec_jal) begin
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
        end else if (dec_branch) begin
          alu_src_a     = 1'b1;
          alu_op_c      = 2'd1;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          branch_ne     = dec_bne;
        end else if (dec_addi || dec_lw || dec_sw) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = dec_addi ? S_WB : S_MEM;
        end else if (dec_logi) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op_c  = 2'd3;
          state_d   = S_WB;
        end else if (dec_lui) begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = dec_lw;
        mem_write = dec_sw;
        if (mem_ready) begin
          state_d = dec_lw ? S_WB : S_FETCH;
        end else if (mem_timeout) begin
          mem_fault = 1'b1;
          state_d   = S_FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
        if (dec_rtype) begin
          reg_dst = 2'b01;
        end else if (dec_lw) begin
          mem_to_reg = 2'b01;
        end else if (dec_lui) begin
          mem_to_reg = 2'b11;
        end
      end
`ifdef MULTICYCLE_CONTROL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_FETCH;
    endcase

    // Stall outranks ready and timeout: hold everything, mask writes.
    if (stall) begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      trap_d        = trap_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      mem_fault     = 1'b0;
    end

    // The current state may be mid-instruction; nothing may escape while
    // the reset is being applied.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      pc_source     = 2'b00;
      ir_write      = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 2'b00;
      mem_to_reg    = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op_c      = 2'd0;
      shamt_sel     = 1'b0;
      mem_fault     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
    end
  end

  assign alu_op = ALU_OP_WIDTH'(alu_op_c);
  assign state  = state_q;
  assign trap   = trap_q & ~rst;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control

module tb_multicycle_control;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst, mem_ready, stall;
  logic [5:0] opcode, funct;
  logic       pc_write, pc_write_cond, branch_ne, ir_write, i_or_d;
  logic       mem_read, mem_write, reg_write, alu_src_a, shamt_sel;
  logic       mem_fault, trap;
  logic [1:0] pc_source, reg_dst, mem_to_reg, alu_src_b;
  logic [2:0] alu_op, state;

  multicycle_control #(.MEM_TIMEOUT(T), .ALU_OP_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .stall(stall),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_source(pc_source), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .shamt_sel(shamt_sel),
    .state(state), .mem_fault(mem_fault), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] state;
    logic       pc_write, pc_write_cond, branch_ne;
    logic [1:0] pc_source;
    logic       ir_write, i_or_d, mem_read, mem_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       shamt_sel, mem_fault, trap;
  } exp_t;

  typedef enum int {C_R, C_SHIFT, C_JR, C_JALR, C_J, C_JAL, C_BR, C_ADDI,
                    C_LOGI, C_LUI, C_LW, C_SW, C_UNDEF} cls_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [11:0] tbl [0:19] = '{
    {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h2A}, {6'h00, 6'h00},
    {6'h00, 6'h02}, {6'h00, 6'h08}, {6'h00, 6'h09}, {6'h02, 6'h11},
    {6'h03, 6'h05}, {6'h04, 6'h20}, {6'h05, 6'h07}, {6'h08, 6'h00},
    {6'h0C, 6'h3F}, {6'h0D, 6'h01}, {6'h0E, 6'h10}, {6'h0F, 6'h00},
    {6'h23, 6'h12}, {6'h2B, 6'h2B}, {6'h3F, 6'h00}, {6'h00, 6'h01}
  };

  function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
    cls_t c;
    c = C_UNDEF;
    case (op)
      6'h00: case (fn)
        6'h00, 6'h02: c = C_SHIFT;
        6'h08: c = C_JR;
        6'h09: c = C_JALR;
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
        6'h2A, 6'h2B: c = C_R;
        default: c = C_UNDEF;
      endcase
      6'h02: c = C_J;
      6'h03: c = C_JAL;
      6'h04, 6'h05: c = C_BR;
      6'h08: c = C_ADDI;
      6'h0C, 6'h0D, 6'h0E: c = C_LOGI;
      6'h0F: c = C_LUI;
      6'h23: c = C_LW;
      6'h2B: c = C_SW;
      default: c = C_UNDEF;
    endcase
    return c;
  endfunction

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e;
    e = '0;
    e.state = st;
    return e;
  endfunction

  function automatic exp_t mask_w(input exp_t e0);
    exp_t e;
    e = e0;
    e.pc_write = 0; e.pc_write_cond = 0; e.ir_write = 0;
    e.mem_write = 0; e.reg_write = 0; e.mem_fault = 0;
    return e;
  endfunction

  function automatic exp_t fetch_out(input bit rdy);
    exp_t e;
    e = blank(3'd0);
    e.mem_read = 1; e.alu_src_b = 2'b01;
    e.ir_write = rdy; e.pc_write = rdy;
    return e;
  endfunction

  function automatic exp_t decode_out();
    exp_t e;
    e = blank(3'd1);
    e.alu_src_b = 2'b11;
    return e;
  endfunction

  function automatic exp_t exec_out(input cls_t c, input logic [5:0] op);
    exp_t e;
    e = blank(3'd2);
    case (c)
      C_R, C_SHIFT: begin
        e.alu_src_a = 1; e.alu_op = 3'd2; e.shamt_sel = (c == C_SHIFT);
      end
      C_JR, C_JALR: begin
        e.pc_write = 1; e.pc_source = 2'b11;
        if (c == C_JALR) begin e.reg_write = 1; e.reg_dst = 2'b01; e.mem_to_reg = 2'b10; end
      end
      C_J, C_JAL: begin
        e.pc_write = 1; e.pc_source = 2'b10;
        if (c == C_JAL) begin e.reg_write = 1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; end
      end
      C_BR: begin
        e.alu_src_a = 1; e.alu_op = 3'd1; e.pc_write_cond = 1;
        e.pc_source = 2'b01; e.branch_ne = (op == 6'h05);
      end
      C_ADDI, C_LW, C_SW: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      C_LOGI: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 3'd3; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t mem_out(input cls_t c);
    exp_t e;
    e = blank(3'd3);
    e.i_or_d = 1; e.mem_read = (c == C_LW); e.mem_write = (c == C_SW);
    return e;
  endfunction

  function automatic exp_t wb_out(input cls_t c);
    exp_t e;
    e = blank(3'd4);
    e.reg_write = 1;
    if (c == C_R || c == C_SHIFT) e.reg_dst = 2'b01;
    if (c == C_LW)  e.mem_to_reg = 2'b01;
    if (c == C_LUI) e.mem_to_reg = 2'b11;
    return e;
  endfunction

  task automatic drive(input exp_t e, input logic rdy, input logic st, input logic r);
    mem_ready = rdy;
    stall     = st;
    rst       = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic plain_phase(input exp_t e, input int sp);
    for (int k = 0; k < 3 && $urandom_range(0, 99) < sp; k++)
      drive(mask_w(e), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    drive(e, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  // One memory access: ready after `waits` unstalled cycles, or a fault
  // once T unstalled cycles pass without ready.
  task automatic mem_phase(input exp_t wait_e, input exp_t rdy_e, input int waits,
                           input int sp, output bit ok);
    int   cnt;
    exp_t e;
    cnt = 0;
    ok  = 1'b0;
    for (int g = 0; g < 64; g++) begin
      if ($urandom_range(0, 99) < sp) begin
        drive(mask_w(wait_e), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      end else if (cnt == waits) begin
        drive(rdy_e, 1'b1, 1'b0, 1'b0);
        ok = 1'b1;
        return;
      end else if (cnt == T - 1) begin
        e = wait_e;
        e.mem_fault = 1;
        drive(e, 1'b0, 1'b0, 1'b0);
        return;
      end else begin
        drive(wait_e, 1'b0, 1'b0, 1'b0);
        cnt++;
      end
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input int sp);
    cls_t c;
    bit   ok;
    exp_t e;
    c = classify(op, fn);
    opcode = op;
    funct  = fn;
    mem_phase(fetch_out(1'b0), fetch_out(1'b1), fw, sp, ok);
    if (!ok) return;
    plain_phase(decode_out(), sp);
    if (c == C_UNDEF) begin
`ifdef MULTICYCLE_CONTROL_TRAP_EN
      e = blank(3'd5);
      e.trap = 1;
      for (int k = 0; k < 3; k++)
        drive(e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      e.trap = 0;
      drive(e, 1'b0, 1'b0, 1'b1);
`endif
      return;
    end
    plain_phase(exec_out(c, op), sp);
    if (c == C_LW || c == C_SW) begin
      mem_phase(mem_out(c), mem_out(c), mw, sp, ok);
      if (!ok) return;
    end
    if (c inside {C_R, C_SHIFT, C_ADDI, C_LOGI, C_LUI, C_LW})
      plain_phase(wb_out(c), sp);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e, act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {state, pc_write, pc_write_cond, branch_ne, pc_source, ir_write, i_or_d,
             mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
             alu_src_b, alu_op, shamt_sel, mem_fault, trap};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs check %0d at %0t: actual %h required %h (state %0d vs %0d)",
                 checks, $time, act, e, act.state, e.state);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t e;
    int   fw, mw, sp, idx;
    rst = 1'b1; mem_ready = 1'b0; stall = 1'b0; opcode = '0; funct = '0;
    @(posedge clk);
    #1;
    drive(blank(3'd0), 1'b0, 1'b0, 1'b1);
    drive(blank(3'd0), 1'b1, 1'b1, 1'b1);

    run_instr(6'h00, 6'h20, 0, 0, 0);
    run_instr(6'h23, 6'h00, 2, 3, 0);
    run_instr(6'h05, 6'h00, 0, 0, 0);
    run_instr(6'h03, 6'h00, 0, 0, 0);
    run_instr(6'h2B, 6'h00, 0, 1000, 0);
    run_instr(6'h23, 6'h00, T - 1, T - 1, 0);
    run_instr(6'h00, 6'h00, T, 0, 0);

    // SW timeout with a stall mid-wait: ready during the stall is ignored
    // and the fault still needs T unstalled wait cycles.
    opcode = 6'h2B; funct = 6'h00;
    drive(fetch_out(1'b1), 1'b1, 1'b0, 1'b0);
    drive(decode_out(), 1'b0, 1'b0, 1'b0);
    drive(exec_out(C_SW, 6'h2B), 1'b0, 1'b0, 1'b0);
    drive(mem_out(C_SW), 1'b0, 1'b0, 1'b0);
    drive(mem_out(C_SW), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive(mask_w(mem_out(C_SW)), 1'b1, 1'b1, 1'b0);
    drive(mem_out(C_SW), 1'b0, 1'b0, 1'b0);
    e = mem_out(C_SW);
    e.mem_fault = 1;
    drive(e, 1'b0, 1'b0, 1'b0);

    run_instr(6'h3F, 6'h00, 0, 0, 0);

    // Reset mid-instruction: JAL in EXEC, then LW waiting in MEM.
    opcode = 6'h03;
    drive(fetch_out(1'b1), 1'b1, 1'b0, 1'b0);
    drive(decode_out(), 1'b0, 1'b0, 1'b0);
    drive(blank(3'd2), 1'b1, 1'b0, 1'b1);
    opcode = 6'h23;
    drive(fetch_out(1'b1), 1'b1, 1'b0, 1'b0);
    drive(decode_out(), 1'b0, 1'b0, 1'b0);
    drive(exec_out(C_LW, 6'h23), 1'b0, 1'b0, 1'b0);
    drive(mem_out(C_LW), 1'b0, 1'b0, 1'b0);
    drive(blank(3'd3), 1'b1, 1'b0, 1'b1);

    for (int n = 0; n < 200; n++) begin
      idx = $urandom_range(0, 19);
      fw  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, T + 1) : 0;
      mw  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, T + 1) : 0;
      sp  = ($urandom_range(0, 1) == 0) ? 25 : 0;
      run_instr(tbl[idx][11:6], tbl[idx][5:0], fw, mw, sp);
    end

    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: actual %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle MIPS control unit replacing the single-cycle opcode decoder in the CPU datapath. It is a Moore/Mealy FSM that sequences FETCH, DECODE, EXEC, MEM and WB per instruction and drives per-cycle datapath strobes. It waits on a variable-latency memory handshake with a parametrised timeout, and supports an external stall. It decodes the same ISA subset: R-type, JR, JALR, SLL, SRL, J, JAL, BEQ, BNE, ADDI, ANDI, ORI, XORI, LUI, LW, SW.

## Interface
- MEM_TIMEOUT, 16: max wait cycles for `mem_ready` per access before fault; must be ≥1.
- ALU_OP_WIDTH, 2: width of `alu_op`; values above 2 zero-extend the encodings.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; sampled in DECODE and later states.
- funct  in  6  IR[5:0].
- mem_ready  in  1  memory completes the current access this cycle.
- stall  in  1  freeze FSM and counter; all write strobes forced 0.
- pc_write, pc_write_cond, branch_ne  out  1  PC unconditional write / branch write gated by ALU zero / invert zero.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs.
- ir_write, i_or_d, mem_read, mem_write, reg_write  out  1 each.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC, 11 imm<<16.
- alu_src_a  out  1  0 PC, 1 rs.
- alu_src_b  out  2  00 rt, 01 const 4, 10 sext imm, 11 sext imm<<2.
- alu_op  out  ALU_OP_WIDTH  0 add, 1 sub, 2 funct, 3 immediate logic.
- shamt_sel  out  1  SLL/SRL, ALU A takes shamt.
- state  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 5.
- mem_fault, trap  out  1  one-cycle timeout pulse / sticky trap flag.

## Operation
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=add. On `mem_ready`: ir_write=1, pc_write=1, pc_source=00, go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=add (branch target into ALUOut). Go to EXEC.
- EXEC, by opcode:
  - R-type: alu_src_a=1, alu_src_b=00, alu_op=funct, shamt_sel for SLL/SRL, then WB.
  - JR: pc_write, pc_source=11, then FETCH.
  - JALR: as JR plus reg_write, reg_dst=01, mem_to_reg=10.
  - ADDI/LW/SW: alu_src_a=1, alu_src_b=10, add. ADDI→WB, LW/SW→MEM.
  - ANDI/ORI/XORI: same with alu_op=3, then WB. LUI: no ALU, then WB.
  - BEQ/BNE: alu_src_a=1, alu_src_b=00, sub, pc_write_cond=1, pc_source=01, branch_ne=BNE, then FETCH.
  - J: pc_write, pc_source=10, then FETCH. JAL: as J plus reg_write, reg_dst=10, mem_to_reg=10.
- MEM: i_or_d=1. LW: mem_read, on ready go to WB. SW: mem_write held until ready, then FETCH.
- WB: reg_write=1. R-type uses reg_dst=01, mem_to_reg=00. LW uses 00/01. LUI uses 00/11. Immediates use 00/00. Then FETCH.
- Outputs not listed for a state are 0.

## Timing
- Reset: state=FETCH, counter=0, trap=0. All strobes are 0 during the `rst` cycle. FETCH strobes appear the cycle after rst deasserts. Reset mid-instruction aborts with no writes.
- Latency with zero wait:
  - Branches, jumps, JR, JALR, JAL: 3 cycles.
  - R-type, immediates, LUI, SW: 4 cycles.
  - LW: 5 cycles.
  - Each memory wait cycle adds 1.
- Wait counter: counts cycles in FETCH/MEM without `mem_ready` and clears on state change. If it reaches MEM_TIMEOUT without ready, `mem_fault` pulses for 1 cycle, the instruction is aborted with no reg_write and no pc_write, and the FSM goes to FETCH.
- `mem_ready` in the same cycle as the timeout: ready wins.
- `stall` has priority over `mem_ready` and the timeout. The ready is ignored and the counter is held.
- mem_read/mem_write stay asserted through waits and are dropped the cycle after ready.

## Configuration
- MULTICYCLE_CONTROL_TRAP_EN defined:
  - Undefined opcode, or undefined R-type funct, in DECODE goes to TRAP and sets `trap` sticky.
  - TRAP holds all strobes 0 until `rst`.
- Undefined: undefined encodings execute as NOP (DECODE→FETCH, 2 cycles plus fetch waits), `trap` is tied 0, and state 5 is unreachable.

## Test plan
- ADD (opcode 0x00, funct 0x20), mem_ready always 1 -> states 0,1,2,4. reg_write=1 only in cycle 4 with reg_dst=01.
- LW (0x23), fetch ready after 2 waits, MEM ready after 3 waits -> 10 cycles total. MDR written back with mem_to_reg=01.
- BNE (0x05) -> EXEC has pc_write_cond=1, branch_ne=1, pc_source=01. Next state FETCH at cycle 3.
- JAL (0x03) -> EXEC has pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10.
- MEM_TIMEOUT=4, SW with mem_ready never asserted -> mem_fault pulses after 4 MEM cycles, no writes, state returns to 0. Repeat with stall=1 mid-wait: the counter freezes.
- Opcode 0x3F with TRAP_EN -> state 5, trap=1 until rst. Without TRAP_EN -> back to FETCH after DECODE, no strobes.
